// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array edge feeders.
//   REG_*         : shift_reg command encoding; also decoded by shift_reg itself
//   feed_state_t  : sequencer states of systolic_feed_ctrl
package systolic_pkg;

    localparam logic [1:0] REG_UPLOAD = 2'd0;   // contents held, doubles as idle
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_WRITE  = 2'd2;
    localparam logic [1:0] REG_READ   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FEED,
        DRAIN,
        DONE
    } feed_state_t;

endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Control/status bundle between a run requester and systolic_feed_ctrl.
//   start      : request a run (master -> slave)
//   passes     : feed passes per run, 0 means 1 (master -> slave)
//   ctrl_code  : per-row shift_reg command, row r at [2r+1:2r] (slave -> master)
//   feed_valid : row r data_read holds a valid word (slave -> master)
//   busy, done : run in progress / single-cycle completion pulse (slave -> master)
interface systolic_feed_ctrl_if #(
    parameter int ROWS = 4
);
    logic                start;
    logic [7:0]          passes;
    logic [2*ROWS-1:0]   ctrl_code;
    logic [ROWS-1:0]     feed_valid;
    logic                busy;
    logic                done;

    modport master (
        output start, passes,
        input  ctrl_code, feed_valid, busy, done
    );

    modport slave (
        input  start, passes,
        output ctrl_code, feed_valid, busy, done
    );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sequencer for a bank of ROWS shift_reg instances feeding one systolic edge.
// Loads all rows in parallel, then streams LENGTH words per row with a
// diagonal skew (row r lags row 0 by r cycles), for a programmable number of
// passes, then pulses done.
//   clock   : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : systolic_feed_ctrl_if.slave (start/passes in, ctrl_code,
//             feed_valid, busy, done out; all outputs registered)
//
// state | meaning
// IDLE  | all rows UPLOAD, waiting for start
// LOAD  | one cycle, all rows LOAD in parallel
// FEED  | t = 0..LENGTH+ROWS-2, row r READ while r <= t < r+LENGTH
// DRAIN | one cycle between passes, all rows UPLOAD
// DONE  | one cycle, done pulse; also settles the last pass's final word
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int LENGTH = 4,
    parameter int CNT_W  = $clog2(LENGTH + ROWS)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    systolic_feed_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(LENGTH + ROWS - 2);

    feed_state_t      state, state_nxt;
    logic [CNT_W-1:0] t, t_nxt;
    logic [7:0]       pass_cnt, pass_cnt_nxt;
    logic [7:0]       passes_eff, passes_eff_nxt;
    logic             last_pass;

    assign last_pass = ({1'b0, pass_cnt} + 9'd1) >= {1'b0, passes_eff};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            t          <= '0;
            pass_cnt   <= '0;
            passes_eff <= 8'd1;
        end else begin
            state      <= state_nxt;
            t          <= t_nxt;
            pass_cnt   <= pass_cnt_nxt;
            passes_eff <= passes_eff_nxt;
        end
    end

    // The final pass goes straight from its last FEED cycle to DONE, so the
    // DONE cycle carries that pass's last feed_valid and one-pass runs keep
    // the L+R+1 completion cycle.
    always_comb begin
        state_nxt      = state;
        t_nxt          = t;
        pass_cnt_nxt   = pass_cnt;
        passes_eff_nxt = passes_eff;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    passes_eff_nxt = (bus.passes == 8'd0) ? 8'd1 : bus.passes;
                    state_nxt      = LOAD;
                end
            end
            LOAD: begin
                t_nxt        = '0;
                pass_cnt_nxt = '0;
                state_nxt    = FEED;
            end
            FEED: begin
                if (t == T_LAST) begin
                    state_nxt = last_pass ? DONE : DRAIN;
                end else begin
                    t_nxt = t + CNT_W'(1);
                end
            end
            DRAIN: begin
                pass_cnt_nxt = pass_cnt + 8'd1;
                t_nxt        = '0;
                state_nxt    = FEED;
            end
            DONE: begin
                t_nxt        = '0;
                pass_cnt_nxt = '0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so each command is
    // on the pins in the same cycle the FSM occupies the matching state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.busy <= (state_nxt != IDLE);
            bus.done <= (state_nxt == DONE);
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam logic [CNT_W:0] WIN_LO = (CNT_W+1)'(r);
        localparam logic [CNT_W:0] WIN_HI = (CNT_W+1)'(r + LENGTH);

        logic       read_win;
        logic [1:0] code_nxt;
        logic [1:0] code_q;
        logic       valid_q;

        assign read_win = (state_nxt == FEED)
                        && ({1'b0, t_nxt} >= WIN_LO)
                        && ({1'b0, t_nxt} <  WIN_HI);

        always_comb begin
            code_nxt = REG_UPLOAD;
            if (state_nxt == LOAD) begin
                code_nxt = REG_LOAD;
            end else if (read_win) begin
                code_nxt = REG_READ;
            end
        end

        // feed_valid trails the READ command by one cycle, matching the
        // registered data_read of shift_reg.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                code_q  <= REG_UPLOAD;
                valid_q <= 1'b0;
            end else begin
                code_q  <= code_nxt;
                valid_q <= (code_q == REG_READ);
            end
        end

        assign bus.ctrl_code[2*r +: 2] = code_q;
        assign bus.feed_valid[r]       = valid_q;
    end

endmodule
